// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory request/response, downstream issue.
// master = fetch unit side, slave = memory / decode side.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;

  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  if_ready,
    output imem_req_valid, imem_req_addr,
    output if_valid, if_pc, if_inst
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output if_ready,
    input  imem_req_valid, imem_req_addr,
    input  if_valid, if_pc, if_inst
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, one outstanding imem request, {pc, inst} issue downstream.
// Optional FETCH_PERF_EN adds perf_fetched / perf_wait_cycles counters.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus,
  output logic [1:0]   state_dbg
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_wait_cycles
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a valid
  // producer holds its payload stable until then, except when a redirect retargets it.
  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            kill, kill_n;
  logic            capture;
  logic [XLEN-1:0] out_pc, out_inst;
  logic [XLEN-1:0] redirect_tgt;

  assign redirect_tgt = bus.redirect_pc & ~XLEN'(3);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    kill_n  = kill;
    capture = 1'b0;
    case (state)
      BOOT: state_n = REQ;
      REQ: begin
        if (bus.redirect_valid) begin
          pc_n = redirect_tgt;
          // The old-address request still goes out; its response must be dropped.
          if (bus.imem_req_ready) begin
            state_n = WAIT;
            kill_n  = 1'b1;
          end
        end else if (bus.imem_req_ready) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_resp_valid) begin
          kill_n = 1'b0;
          if (bus.redirect_valid) begin
            pc_n    = redirect_tgt;
            state_n = REQ;
          end else if (kill) begin
            state_n = REQ;
          end else begin
            capture = 1'b1;
            state_n = HOLD;
          end
        end else if (bus.redirect_valid) begin
          pc_n   = redirect_tgt;
          kill_n = 1'b1;
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          pc_n    = redirect_tgt;
          state_n = REQ;
        end else if (bus.if_ready) begin
          pc_n    = pc + XLEN'(4);
          state_n = REQ;
        end
      end
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      kill     <= 1'b0;
      out_pc   <= '0;
      out_inst <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      kill  <= kill_n;
      if (capture) begin
        out_pc   <= pc;
        out_inst <= bus.imem_resp_data;
      end
    end
  end

  assign bus.imem_req_valid = (state == REQ);
  assign bus.imem_req_addr  = pc;
  assign bus.if_valid       = (state == HOLD);
  assign bus.if_pc          = out_pc;
  assign bus.if_inst        = out_inst;
  assign state_dbg          = state;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched     <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (state == HOLD && bus.if_ready && !bus.redirect_valid)
        perf_fetched <= perf_fetched + 32'd1;
      if (state == WAIT)
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder returning 0x1000+addr,
// downstream monitor, and per-scenario tasks comparing against an expected queue.
module tb_fetch_unit;
  localparam int          XLEN   = 32;
  localparam logic [31:0] RST_PC = 32'h100;
  localparam logic [1:0]  S_REQ  = 2'd1;
  localparam logic [1:0]  S_WAIT = 2'd2;
  localparam logic [1:0]  S_HOLD = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_wait_cycles;
`endif

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .state_dbg(state_dbg)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_wait_cycles(perf_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory responder (sole driver of req_ready / resp_*) -------------
  int          mem_lat = 1;
  int          stall_until = 0;
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  int          acc_cnt = 0;
  int          overlap_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_pend = 0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data = '0;
      bus.imem_req_ready = 1'b1;
    end else begin
      bus.imem_resp_valid = 1'b0;
      if (mem_pend) begin
        if (mem_cnt == 0) begin
          bus.imem_resp_valid = 1'b1;
          bus.imem_resp_data = 32'h1000 + mem_addr;
          mem_pend = 0;
        end else begin
          mem_cnt--;
        end
      end
      bus.imem_req_ready = (cyc >= stall_until);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (mem_pend || bus.imem_resp_valid) overlap_cnt++;
        mem_pend = 1;
        mem_cnt = mem_lat - 1;
        mem_addr = bus.imem_req_addr;
        acc_cnt++;
      end
    end
  end

  // ---------------- downstream monitor (records completed issues) --------------------
  logic [31:0] obs_pc[$];
  logic [31:0] obs_inst[$];
  int          obs_cyc[$];
  int          hs_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) hs_cnt = 0;
    else if (bus.if_valid && bus.if_ready && !bus.redirect_valid) begin
      obs_pc.push_back(bus.if_pc);
      obs_inst.push_back(bus.if_inst);
      obs_cyc.push_back(cyc);
      hs_cnt++;
    end
  end

  // ---------------- scoreboard state and counters ------------------------------------
  logic [63:0] exp_q[$];
  int          obs_rd = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s, output bit ok);
    int n = 0;
    while (state_dbg != s && n < 100) begin tick(); n++; end
    ok = (state_dbg == s);
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (bus.imem_req_valid !== 1'b1 && n < 100) begin tick(); n++; end
    ok = (bus.imem_req_valid === 1'b1);
  endtask

  task automatic wait_obs(input int target, output bit ok);
    int n = 0;
    while (obs_pc.size() < target && n < 200) begin tick(); n++; end
    ok = (obs_pc.size() >= target);
  endtask

  task automatic test_reset();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.if_ready = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (bus.imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); else n_pass++;
    n_checks++; if (bus.if_valid !== 1'b0) $display("FAIL reset_if_valid: got %b want 0", bus.if_valid); else n_pass++;
    n_checks++; if (bus.if_pc !== 32'h0) $display("FAIL reset_if_pc: got %h want 0", bus.if_pc); else n_pass++;
    n_checks++; if (bus.if_inst !== 32'h0) $display("FAIL reset_if_inst: got %h want 0", bus.if_inst); else n_pass++;
    n_checks++; if (bus.imem_req_addr !== RST_PC) $display("FAIL reset_addr: got %h want %h", bus.imem_req_addr, RST_PC); else n_pass++;
    rst_n = 1'b1;
    n_checks++; if (bus.imem_req_valid !== 1'b0) $display("FAIL boot_req_valid: got %b want 0", bus.imem_req_valid); else n_pass++;
    tick();
    n_checks++; if (bus.imem_req_valid !== 1'b1) $display("FAIL first_req_valid: got %b want 1", bus.imem_req_valid); else n_pass++;
    n_checks++; if (bus.imem_req_addr !== RST_PC) $display("FAIL first_req_addr: got %h want %h", bus.imem_req_addr, RST_PC); else n_pass++;
  endtask

  task automatic test_stream();
    bit ok;
    int base = obs_pc.size();
    logic [63:0] e;
    for (int i = 0; i < 3; i++) exp_q.push_back({RST_PC + 32'(4 * i), 32'h1100 + 32'(4 * i)});
    wait_obs(base + 3, ok);
    bus.if_ready = 1'b0;
    n_checks++; if (!ok) $display("FAIL stream_timeout: got %0d issues want %0d", obs_pc.size() - base, 3); else n_pass++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_rd >= obs_pc.size()) $display("FAIL stream_issue: got none want %h", e);
      else if ({obs_pc[obs_rd], obs_inst[obs_rd]} !== e) $display("FAIL stream_issue: got %h_%h want %h", obs_pc[obs_rd], obs_inst[obs_rd], e);
      else n_pass++;
      obs_rd++;
    end
    if (ok) begin
      n_checks++; if (obs_cyc[base + 1] - obs_cyc[base] != 3) $display("FAIL stream_gap1: got %0d want 3", obs_cyc[base + 1] - obs_cyc[base]); else n_pass++;
      n_checks++; if (obs_cyc[base + 2] - obs_cyc[base + 1] != 3) $display("FAIL stream_gap2: got %0d want 3", obs_cyc[base + 2] - obs_cyc[base + 1]); else n_pass++;
    end
  endtask

  task automatic test_hold_stall();
    bit ok;
    int a0;
    logic [63:0] e;
    wait_state(S_HOLD, ok);
    n_checks++; if (!ok) $display("FAIL hold_reach: got state %0d want %0d", state_dbg, S_HOLD); else n_pass++;
    a0 = acc_cnt;
    exp_q.push_back({32'h10c, 32'h110c});
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.if_valid !== 1'b1) $display("FAIL hold_valid: got %b want 1", bus.if_valid); else n_pass++;
      n_checks++; if (bus.if_pc !== 32'h10c) $display("FAIL hold_pc: got %h want 10c", bus.if_pc); else n_pass++;
      n_checks++; if (bus.if_inst !== 32'h110c) $display("FAIL hold_inst: got %h want 110c", bus.if_inst); else n_pass++;
      n_checks++; if (bus.imem_req_valid !== 1'b0) $display("FAIL hold_no_req: got %b want 0", bus.imem_req_valid); else n_pass++;
      tick();
    end
    n_checks++; if (acc_cnt != a0) $display("FAIL hold_accepts: got %0d want %0d", acc_cnt, a0); else n_pass++;
    bus.if_ready = 1'b1;
    tick();
    bus.if_ready = 1'b0;
    n_checks++; if (bus.imem_req_valid !== 1'b1) $display("FAIL hold_next_req: got %b want 1", bus.imem_req_valid); else n_pass++;
    n_checks++; if (bus.imem_req_addr !== 32'h110) $display("FAIL hold_next_addr: got %h want 110", bus.imem_req_addr); else n_pass++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_rd >= obs_pc.size()) $display("FAIL hold_issue: got none want %h", e);
      else if ({obs_pc[obs_rd], obs_inst[obs_rd]} !== e) $display("FAIL hold_issue: got %h_%h want %h", obs_pc[obs_rd], obs_inst[obs_rd], e);
      else n_pass++;
      obs_rd++;
    end
  endtask

  task automatic test_req_stall();
    bit ok;
    int a0 = acc_cnt;
    logic [63:0] e;
    stall_until = cyc + 5;
    exp_q.push_back({32'h110, 32'h1110});
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.imem_req_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", bus.imem_req_valid); else n_pass++;
      n_checks++; if (bus.imem_req_addr !== 32'h110) $display("FAIL stall_addr: got %h want 110", bus.imem_req_addr); else n_pass++;
      tick();
    end
    wait_state(S_HOLD, ok);
    n_checks++; if (!ok) $display("FAIL stall_hold: got state %0d want %0d", state_dbg, S_HOLD); else n_pass++;
    n_checks++; if (acc_cnt != a0 + 1) $display("FAIL stall_accepts: got %0d want %0d", acc_cnt - a0, 1); else n_pass++;
    bus.if_ready = 1'b1;
    tick();
    bus.if_ready = 1'b0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_rd >= obs_pc.size()) $display("FAIL stall_issue: got none want %h", e);
      else if ({obs_pc[obs_rd], obs_inst[obs_rd]} !== e) $display("FAIL stall_issue: got %h_%h want %h", obs_pc[obs_rd], obs_inst[obs_rd], e);
      else n_pass++;
      obs_rd++;
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    logic [63:0] e;
    // Redirect coincides with the response: that response must be dropped.
    wait_state(S_WAIT, ok);
    n_checks++; if (!ok) $display("FAIL rw_reach1: got state %0d want %0d", state_dbg, S_WAIT); else n_pass++;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h203;
    tick();
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.imem_req_valid !== 1'b1) $display("FAIL rw_req1: got %b want 1", bus.imem_req_valid); else n_pass++;
    n_checks++; if (bus.imem_req_addr !== 32'h200) $display("FAIL rw_addr1: got %h want 200", bus.imem_req_addr); else n_pass++;
    mem_lat = 3;
    exp_q.push_back({32'h200, 32'h1200});
    bus.if_ready = 1'b1;
    wait_obs(obs_rd + 1, ok);
    bus.if_ready = 1'b0;
    n_checks++; if (!ok) $display("FAIL rw_issue_timeout: got %0d want %0d", obs_pc.size(), obs_rd + 1); else n_pass++;
    // Redirect ahead of a slow response: kill must swallow it later.
    wait_state(S_WAIT, ok);
    n_checks++; if (!ok) $display("FAIL rw_reach2: got state %0d want %0d", state_dbg, S_WAIT); else n_pass++;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h302;
    tick();
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.imem_req_valid !== 1'b0) $display("FAIL rw_kill_wait: got %b want 0", bus.imem_req_valid); else n_pass++;
    wait_req(ok);
    n_checks++; if (!ok) $display("FAIL rw_req2_timeout: got %b want 1", bus.imem_req_valid); else n_pass++;
    n_checks++; if (bus.imem_req_addr !== 32'h300) $display("FAIL rw_addr2: got %h want 300", bus.imem_req_addr); else n_pass++;
    mem_lat = 1;
    exp_q.push_back({32'h300, 32'h1300});
    bus.if_ready = 1'b1;
    wait_obs(obs_rd + 2, ok);
    bus.if_ready = 1'b0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_rd >= obs_pc.size()) $display("FAIL rw_issue: got none want %h", e);
      else if ({obs_pc[obs_rd], obs_inst[obs_rd]} !== e) $display("FAIL rw_issue: got %h_%h want %h", obs_pc[obs_rd], obs_inst[obs_rd], e);
      else n_pass++;
      obs_rd++;
    end
  endtask

  task automatic test_redirect_hold();
    bit ok;
    logic [63:0] e;
    wait_state(S_HOLD, ok);
    n_checks++; if (!ok) $display("FAIL rh_reach: got state %0d want %0d", state_dbg, S_HOLD); else n_pass++;
    n_checks++; if (bus.if_pc !== 32'h304) $display("FAIL rh_held_pc: got %h want 304", bus.if_pc); else n_pass++;
    bus.if_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h400;
    tick();
    bus.redirect_valid = 1'b0;
    bus.if_ready = 1'b0;
    n_checks++; if (bus.if_valid !== 1'b0) $display("FAIL rh_if_valid: got %b want 0", bus.if_valid); else n_pass++;
    n_checks++; if (bus.imem_req_valid !== 1'b1) $display("FAIL rh_req: got %b want 1", bus.imem_req_valid); else n_pass++;
    n_checks++; if (bus.imem_req_addr !== 32'h400) $display("FAIL rh_addr: got %h want 400", bus.imem_req_addr); else n_pass++;
`ifdef FETCH_PERF_EN
    n_checks++; if (perf_fetched !== 32'(hs_cnt)) $display("FAIL rh_perf_fetched: got %0d want %0d", perf_fetched, hs_cnt); else n_pass++;
`endif
    exp_q.push_back({32'h400, 32'h1400});
    bus.if_ready = 1'b1;
    wait_obs(obs_rd + 1, ok);
    bus.if_ready = 1'b0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_rd >= obs_pc.size()) $display("FAIL rh_issue: got none want %h", e);
      else if ({obs_pc[obs_rd], obs_inst[obs_rd]} !== e) $display("FAIL rh_issue: got %h_%h want %h", obs_pc[obs_rd], obs_inst[obs_rd], e);
      else n_pass++;
      obs_rd++;
    end
  endtask

  task automatic test_wrap_and_reset();
    bit ok;
    int a0 = acc_cnt;
    logic [63:0] e;
    // Redirect while the request is stalled: address retargets, nothing extra is issued.
    stall_until = cyc + 2;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.imem_req_valid !== 1'b1) $display("FAIL wrap_req: got %b want 1", bus.imem_req_valid); else n_pass++;
    n_checks++; if (bus.imem_req_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h want fffffffc", bus.imem_req_addr); else n_pass++;
    mem_lat = 3;
    exp_q.push_back({32'hFFFF_FFFC, 32'h0000_0FFC});
    exp_q.push_back({32'h0000_0000, 32'h0000_1000});
    bus.if_ready = 1'b1;
    wait_obs(obs_rd + 2, ok);
    bus.if_ready = 1'b0;
    n_checks++; if (acc_cnt - a0 != 2) $display("FAIL wrap_accepts: got %0d want 2", acc_cnt - a0); else n_pass++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_rd >= obs_pc.size()) $display("FAIL wrap_issue: got none want %h", e);
      else if ({obs_pc[obs_rd], obs_inst[obs_rd]} !== e) $display("FAIL wrap_issue: got %h_%h want %h", obs_pc[obs_rd], obs_inst[obs_rd], e);
      else n_pass++;
      obs_rd++;
    end
    wait_state(S_WAIT, ok);
    n_checks++; if (!ok) $display("FAIL rst_reach_wait: got state %0d want %0d", state_dbg, S_WAIT); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.imem_req_valid !== 1'b0) $display("FAIL rst2_req_valid: got %b want 0", bus.imem_req_valid); else n_pass++;
    n_checks++; if (bus.if_valid !== 1'b0) $display("FAIL rst2_if_valid: got %b want 0", bus.if_valid); else n_pass++;
    n_checks++; if (bus.if_pc !== 32'h0) $display("FAIL rst2_if_pc: got %h want 0", bus.if_pc); else n_pass++;
    n_checks++; if (bus.if_inst !== 32'h0) $display("FAIL rst2_if_inst: got %h want 0", bus.if_inst); else n_pass++;
    n_checks++; if (bus.imem_req_addr !== RST_PC) $display("FAIL rst2_addr: got %h want %h", bus.imem_req_addr, RST_PC); else n_pass++;
`ifdef FETCH_PERF_EN
    n_checks++; if (perf_fetched !== 32'h0) $display("FAIL rst2_perf_fetched: got %0d want 0", perf_fetched); else n_pass++;
    n_checks++; if (perf_wait_cycles !== 32'h0) $display("FAIL rst2_perf_wait: got %0d want 0", perf_wait_cycles); else n_pass++;
`endif
    tick(); tick();
    rst_n = 1'b1;
    wait_req(ok);
    n_checks++; if (!ok) $display("FAIL rst2_req_timeout: got %b want 1", bus.imem_req_valid); else n_pass++;
    n_checks++; if (bus.imem_req_addr !== RST_PC) $display("FAIL rst2_first_addr: got %h want %h", bus.imem_req_addr, RST_PC); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold_stall();
    test_req_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap_and_reset();
    tick(); tick();
    n_checks++; if (obs_pc.size() != obs_rd) $display("FAIL extra_issues: got %0d want %0d", obs_pc.size(), obs_rd); else n_pass++;
    n_checks++; if (overlap_cnt != 0) $display("FAIL outstanding: got %0d overlaps want 0", overlap_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1);
  end

endmodule
